// File: rtl/dma_arb_pkg.sv
// Shared definitions for the DMA arbiter: state encodings, sizes and the timeout limit.
// The optional bus timeout is enabled by defining DMA_ARB_TIMEOUT_EN.
package dma_arb_pkg;

  localparam int N_REQ = 4;
  localparam int AW    = 18;
  localparam int DW    = 16;

  localparam logic [7:0] TIMEOUT_LIMIT = 8'd255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_ACK  = 2'd2
  } state_e;

  function automatic logic [N_REQ-1:0] onehot(input logic [1:0] idx);
    onehot = 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/dma_arb_rr_pick.sv
// Combinational 4-way round-robin priority encoder: search starts at last+1 and wraps.
module rr_pick
  import dma_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [1:0]       last,
  output logic             any,
  output logic [1:0]       idx
);

  logic [1:0] cand_s;

  // Scan from farthest to nearest so the candidate closest after last wins.
  always_comb begin
    any    = |req;
    idx    = 2'd0;
    cand_s = 2'd0;
    for (int i = N_REQ; i >= 1; i--) begin
      cand_s = last + 2'(i);
      if (req[cand_s]) begin
        idx = cand_s;
      end else begin
        idx = idx;
      end
    end
  end

endmodule

// File: rtl/dma_arb.sv
// Four-requester DMA arbiter driving a single memory port (IDLE -> XFER -> ACK).
// Define DMA_ARB_TIMEOUT_EN to add a 255-cycle bus timeout that reports through err.
module dma_arb
  import dma_arb_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] we,
  input  logic [AW-1:0]    addr0,
  input  logic [AW-1:0]    addr1,
  input  logic [AW-1:0]    addr2,
  input  logic [AW-1:0]    addr3,
  input  logic [DW-1:0]    wdata0,
  input  logic [DW-1:0]    wdata1,
  input  logic [DW-1:0]    wdata2,
  input  logic [DW-1:0]    wdata3,
  output logic [N_REQ-1:0] ack,
  output logic             err,
  output logic [DW-1:0]    rdata,
  input  logic             cpu_hold,
  output logic             mem_req,
  output logic             mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic [DW-1:0]    mem_wdata,
  input  logic [DW-1:0]    mem_rdata,
  input  logic             mem_ack,
  output logic [1:0]       grant_id
);

  state_e           state_q, state_d;
  logic [1:0]       last_q, last_d;
  logic [1:0]       gid_q, gid_d;
  logic             we_q, we_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    wdata_q, wdata_d;
  logic [DW-1:0]    rdata_q, rdata_d;
  logic             mem_req_q, mem_req_d;
  logic [N_REQ-1:0] ack_q, ack_d;

  logic             pick_any_s;
  logic [1:0]       pick_idx_s;
  logic [AW-1:0]    addr_s;
  logic [DW-1:0]    wdata_s;

`ifdef DMA_ARB_TIMEOUT_EN
  logic [7:0]       cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  rr_pick u_pick (
    .req  (req),
    .last (last_q),
    .any  (pick_any_s),
    .idx  (pick_idx_s)
  );

  // Select the candidate winner's address and write data.
  always_comb begin
    case (pick_idx_s)
      2'd0:    begin addr_s = addr0; wdata_s = wdata0; end
      2'd1:    begin addr_s = addr1; wdata_s = wdata1; end
      2'd2:    begin addr_s = addr2; wdata_s = wdata2; end
      2'd3:    begin addr_s = addr3; wdata_s = wdata3; end
      default: begin addr_s = addr0; wdata_s = wdata0; end
    endcase
  end

  // Next-state and output logic; a transfer once granted always runs to ACK.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    gid_d     = gid_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    mem_req_d = mem_req_q;
    ack_d     = {N_REQ{1'b0}};
`ifdef DMA_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    err_d     = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_any_s && !cpu_hold) begin
          state_d   = ST_XFER;
          gid_d     = pick_idx_s;
          we_d      = we[pick_idx_s];
          addr_d    = addr_s;
          wdata_d   = wdata_s;
          mem_req_d = 1'b1;
`ifdef DMA_ARB_TIMEOUT_EN
          cnt_d     = 8'd0;
`endif
        end else begin
          mem_req_d = 1'b0;
        end
      end
      ST_XFER: begin
        if (mem_ack) begin
          if (!we_q) begin
            rdata_d = mem_rdata;
          end else begin
            rdata_d = rdata_q;
          end
          mem_req_d = 1'b0;
          ack_d     = onehot(gid_q);
          state_d   = ST_ACK;
`ifdef DMA_ARB_TIMEOUT_EN
        end else if (cnt_q == TIMEOUT_LIMIT) begin
          rdata_d   = {DW{1'b0}};
          mem_req_d = 1'b0;
          ack_d     = onehot(gid_q);
          err_d     = 1'b1;
          state_d   = ST_ACK;
        end else begin
          cnt_d     = cnt_q + 8'd1;
        end
`else
        end else begin
          state_d   = ST_XFER;
        end
`endif
      end
      ST_ACK: begin
        last_d  = gid_q;
        state_d = ST_IDLE;
      end
      default: begin
        mem_req_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; last_q resets to 3 so requester 0 wins first.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      last_q    <= 2'd3;
      gid_q     <= 2'd0;
      we_q      <= 1'b0;
      addr_q    <= {AW{1'b0}};
      wdata_q   <= {DW{1'b0}};
      rdata_q   <= {DW{1'b0}};
      mem_req_q <= 1'b0;
      ack_q     <= {N_REQ{1'b0}};
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      gid_q     <= gid_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      mem_req_q <= mem_req_d;
      ack_q     <= ack_d;
    end
  end

`ifdef DMA_ARB_TIMEOUT_EN
  // Timeout counter and error pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= 8'd0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign ack       = ack_q;
  assign rdata     = rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign grant_id  = gid_q;

endmodule

// File: tb/tb_dma_arb.sv
// Scoreboard bench for dma_arb: stimulus queues expected memory cycles and acks,
// a negedge monitor models the memory and checks whatever the DUT presents.
module tb_dma_arb;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  req = 4'b0000;
  logic [3:0]  tb_we = 4'b0000;
  logic [17:0] tb_addr [4];
  logic [15:0] tb_wdata [4];
  logic        cpu_hold = 1'b0;
  logic [15:0] mem_rdata = 16'h0000;
  logic        mem_ack = 1'b0;

  logic [3:0]  ack;
  logic        err;
  logic [15:0] rdata;
  logic        mem_req;
  logic        mem_we;
  logic [17:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [1:0]  grant_id;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [3:0]  ack;
    logic        err;
    logic [15:0] rdata;
    bit          to;
    int          gap;
  } ack_exp_t;

  typedef struct {
    logic        we;
    logic [17:0] addr;
    logic [15:0] wdata;
    logic [1:0]  gid;
  } mem_exp_t;

  ack_exp_t ack_sb[$];
  mem_exp_t mem_sb[$];

  int          mem_wait = 0;
  bit          mem_en = 1'b1;
  logic [15:0] rd_val = 16'h0000;
  int          xc = 0;
  int          mem_ack_cyc = 0;
  int          xfer_cyc = 0;
  int          last_ack_cyc = 0;
  mem_exp_t    cur_mem;
  bit          cur_ok = 1'b0;
  ack_exp_t    ea;

  dma_arb dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .we        (tb_we),
    .addr0     (tb_addr[0]),
    .addr1     (tb_addr[1]),
    .addr2     (tb_addr[2]),
    .addr3     (tb_addr[3]),
    .wdata0    (tb_wdata[0]),
    .wdata1    (tb_wdata[1]),
    .wdata2    (tb_wdata[2]),
    .wdata3    (tb_wdata[3]),
    .ack       (ack),
    .err       (err),
    .rdata     (rdata),
    .cpu_hold  (cpu_hold),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .grant_id  (grant_id)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
  endtask

  task automatic push_mem(input int idx);
    mem_sb.push_back('{we: tb_we[idx], addr: tb_addr[idx], wdata: tb_wdata[idx], gid: idx[1:0]});
  endtask

  task automatic push_ack(input logic [3:0] a, input logic e, input logic [15:0] rd,
                          input bit to, input int gap);
    ack_sb.push_back('{ack: a, err: e, rdata: rd, to: to, gap: gap});
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input int bound);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (ack == 4'b0000 && n < bound);
    if (ack == 4'b0000) bound_fail("wait_ack");
  endtask

  task automatic wait_mem_req(input int bound);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!mem_req && n < bound);
    if (!mem_req) bound_fail("wait_mem_req");
  endtask

  // Memory model plus ack/memory-side monitor, both evaluated away from the active edge.
  always @(negedge clk) begin
    if (!reset_n) begin
      xc = 0;
      mem_ack = 1'b0;
      cur_ok = 1'b0;
    end else begin
      if (ack !== 4'b0000 || err !== 1'b0) begin
        if (ack_sb.size() == 0) begin
          chk("unexpected_ack", {27'd0, err, ack}, 32'd0);
        end else begin
          ea = ack_sb.pop_front();
          chk("ack", ack, ea.ack);
          chk("err", err, ea.err);
          chk("rdata", rdata, ea.rdata);
          chk("ack_vs_mem_req", mem_req, 1'b0);
          if (ea.to) chk("timeout_latency", cyc - xfer_cyc, 256);
          else       chk("ack_latency", cyc - mem_ack_cyc, 1);
          if (ea.gap != 0) chk("ack_gap", cyc - last_ack_cyc, ea.gap);
          last_ack_cyc = cyc;
        end
      end
      if (mem_req) begin
        xc++;
        if (xc == 1) begin
          xfer_cyc = cyc;
          if (mem_sb.size() == 0) begin
            chk("unexpected_mem_req", mem_req, 1'b0);
            cur_ok = 1'b0;
          end else begin
            cur_mem = mem_sb.pop_front();
            cur_ok = 1'b1;
          end
        end
        if (cur_ok) begin
          chk("mem_we", mem_we, cur_mem.we);
          chk("mem_addr", mem_addr, cur_mem.addr);
          chk("mem_wdata", mem_wdata, cur_mem.wdata);
          chk("grant_id", grant_id, cur_mem.gid);
        end
        if (mem_en && xc > mem_wait) begin
          mem_ack = 1'b1;
          mem_rdata = rd_val;
          mem_ack_cyc = cyc;
        end else begin
          mem_ack = 1'b0;
        end
      end else begin
        xc = 0;
        mem_ack = 1'b0;
        cur_ok = 1'b0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    tb_addr[0] = 18'o1000;    tb_wdata[0] = 16'o123456;
    tb_addr[1] = 18'h1_0001;  tb_wdata[1] = 16'h1111;
    tb_addr[2] = 18'h2_2222;  tb_wdata[2] = 16'h2222;
    tb_addr[3] = 18'h3_FFFF;  tb_wdata[3] = 16'h3333;

    // Reset values
    cycles(3);
    chk("rst_ack", ack, 4'b0000);
    chk("rst_err", err, 1'b0);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 18'd0);
    chk("rst_mem_wdata", mem_wdata, 16'd0);
    chk("rst_rdata", rdata, 16'd0);
    chk("rst_grant_id", grant_id, 2'd0);
    reset_n = 1'b1;
    cycles(2);

    // All four requesting, zero-wait writes: 0,1,2,3,0 three cycles apart
    tb_we = 4'b1111;
    mem_wait = 0;
    push_mem(0); push_mem(1); push_mem(2); push_mem(3); push_mem(0);
    push_ack(4'b0001, 1'b0, 16'h0000, 1'b0, 0);
    push_ack(4'b0010, 1'b0, 16'h0000, 1'b0, 3);
    push_ack(4'b0100, 1'b0, 16'h0000, 1'b0, 3);
    push_ack(4'b1000, 1'b0, 16'h0000, 1'b0, 3);
    push_ack(4'b0001, 1'b0, 16'h0000, 1'b0, 3);
    req = 4'b1111;
    repeat (5) wait_ack(20);
    req = 4'b0000;
    cycles(2);

    // Single write from requester 0, memory acks on the second XFER cycle
    mem_wait = 1;
    push_mem(0);
    push_ack(4'b0001, 1'b0, 16'h0000, 1'b0, 0);
    req = 4'b0001;
    wait_ack(20);
    req = 4'b0000;
    cycles(2);

    // Read from requester 2
    mem_wait = 0;
    tb_we = 4'b1011;
    rd_val = 16'hBEEF;
    push_mem(2);
    push_ack(4'b0100, 1'b0, 16'hBEEF, 1'b0, 0);
    req = 4'b0100;
    wait_ack(20);
    req = 4'b0000;
    cycles(2);

    // req dropped mid-transfer still completes with an ack
    mem_wait = 2;
    rd_val = 16'h1234;
    push_mem(2);
    push_ack(4'b0100, 1'b0, 16'h1234, 1'b0, 0);
    req = 4'b0100;
    wait_mem_req(10);
    req = 4'b0000;
    wait_ack(20);
    cycles(2);

    // cpu_hold rising during XFER: transfer finishes, next grant waits for release
    push_mem(3);
    push_ack(4'b1000, 1'b0, 16'h1234, 1'b0, 0);
    req = 4'b1000;
    wait_mem_req(10);
    cpu_hold = 1'b1;
    wait_ack(20);
    req = 4'b0001;
    push_mem(0);
    push_ack(4'b0001, 1'b0, 16'h1234, 1'b0, 0);
    for (int i = 0; i < 5; i++) begin
      cycles(1);
      chk("hold_after_xfer", mem_req, 1'b0);
    end
    cpu_hold = 1'b0;
    wait_ack(20);
    req = 4'b0000;
    cycles(2);

    // cpu_hold with req=0010 for 10 cycles, then release
    mem_wait = 0;
    cpu_hold = 1'b1;
    req = 4'b0010;
    for (int i = 0; i < 10; i++) begin
      cycles(1);
      chk("hold_mem_req", mem_req, 1'b0);
    end
    push_mem(1);
    push_ack(4'b0010, 1'b0, 16'h1234, 1'b0, 0);
    cpu_hold = 1'b0;
    chk("release_same_cycle", mem_req, 1'b0);
    cycles(1);
    chk("release_mem_req", mem_req, 1'b1);
    wait_ack(20);
    req = 4'b0000;
    cycles(2);

`ifdef DMA_ARB_TIMEOUT_EN
    // Memory never responds: ack+err 256 cycles after XFER entry, rdata forced to 0
    mem_en = 1'b0;
    tb_we = 4'b1010;
    push_mem(0);
    push_ack(4'b0001, 1'b1, 16'h0000, 1'b1, 0);
    req = 4'b0001;
    wait_ack(300);
    req = 4'b0000;
    mem_en = 1'b1;
    tb_we = 4'b1011;
    cycles(2);
`endif

    // Reset mid-XFER: mem_req drops at once, no ack, requester 0 wins next
    mem_wait = 20;
    push_mem(2);
    req = 4'b0100;
    wait_mem_req(10);
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("reset_mem_req", mem_req, 1'b0);
    chk("reset_ack", ack, 4'b0000);
    req = 4'b0000;
    cycles(1);
    reset_n = 1'b1;
    cycles(5);
    mem_wait = 0;
    tb_we = 4'b1111;
    push_mem(0);
    push_ack(4'b0001, 1'b0, 16'h0000, 1'b0, 0);
    req = 4'b1111;
    wait_ack(20);
    req = 4'b0000;
    cycles(5);

    chk("ack_sb_empty", ack_sb.size(), 0);
    chk("mem_sb_empty", mem_sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dma_arb.md
DMA_ARB -- requirements
Module: dma_arb

Interface
REQ-001 clk  input  1  system clock; all state changes on its rising edge.
REQ-002 reset_n  input  1  asynchronous, active-low reset.
REQ-003 req[3:0]  input  4  per-requester DMA request, held high until acknowledged.
REQ-004 we[3:0]  input  4  per-requester direction; 1 = memory write, 0 = memory read; valid while req high.
REQ-005 addr0..addr3  input  18 each  per-requester 18-bit byte address ({mex,ba}).
REQ-006 wdata0..wdata3  input  16 each  per-requester write data.
REQ-007 ack[3:0]  output  4  one-cycle completion pulse to the winning requester.
REQ-008 err  output  1  one-cycle pulse, coincident with ack, on bus timeout.
REQ-009 rdata  output  16  read data, valid in the ack cycle; shared by all requesters.
REQ-010 cpu_hold  input  1  CPU owns memory; blocks new grants only.
REQ-011 mem_req  output  1  memory cycle request.
REQ-012 mem_we  output  1  memory cycle direction.
REQ-013 mem_addr  output  18  memory address.
REQ-014 mem_wdata  output  16  memory write data.
REQ-015 mem_rdata  input  16  memory read data, valid with mem_ack.
REQ-016 mem_ack  input  1  memory cycle complete, single-cycle pulse.
REQ-017 grant_id  output  2  index of the current owner; debug use only.

Function
REQ-018 FSM states: IDLE, XFER, ACK. 2-bit encoding.
REQ-019 IDLE, with any req high and cpu_hold low: select the winner round-robin, starting at last_grant+1 mod 4. Latch its we, addr, wdata and index. Go to XFER on the next edge.
REQ-020 IDLE with cpu_hold high or req==0: stay in IDLE; mem_req stays 0.
REQ-021 XFER: mem_req=1, with mem_we/mem_addr/mem_wdata driven from latched values. Values stay stable until mem_ack.
REQ-022 XFER with mem_ack: capture mem_rdata into rdata (reads only; writes leave rdata unchanged). Go to ACK. mem_req is 0 from the next cycle.
REQ-023 ACK: ack[winner]=1 for exactly one cycle; set last_grant=winner; go to IDLE.
REQ-024 Latency: req sampled in IDLE at cycle N gives mem_req at N+1. mem_ack at cycle M gives ack at M+1. Minimum request-to-ack time is 3 cycles with a zero-wait memory.
REQ-025 A requester drops req on the edge after its ack. A req still high in the following IDLE cycle is treated as a new request.
REQ-026 req dropped during XFER: the cycle completes and ack is still pulsed. No abort.
REQ-027 cpu_hold rising during XFER: the current cycle completes. No new grant until cpu_hold is low.
REQ-028 Only one ack bit is ever high. ack and mem_req are never high in the same cycle.
REQ-029 All four requesters requesting continuously: grants rotate 0,1,2,3,0,... and no requester waits more than 3 transfers.

Reset
REQ-030 reset_n low asynchronously forces: state=IDLE, last_grant=3 (requester 0 wins first), ack=0, err=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, rdata=0, grant_id=0.
REQ-031 Reset during XFER drops mem_req immediately. No ack is issued for the aborted cycle.

Configuration
REQ-032 DMA_ARB_TIMEOUT_EN defined: an 8-bit counter clears on entry to XFER and increments each XFER cycle. When the counter reaches 255 without mem_ack, go to ACK with err=1 and rdata=0. last_grant advances as normal.
REQ-033 DMA_ARB_TIMEOUT_EN undefined: no counter exists, err is tied to 0, and XFER waits indefinitely.

Structure
REQ-034 Shared include dma_arb_defs.vh holds: state encodings, requester count (4), timeout limit (255), address width (18) and data width (16).
REQ-035 Sub-module rr_pick: combinational 4-way round-robin priority encoder. Inputs: req[3:0], last[1:0]. Outputs: any, idx[1:0].

Verification
REQ-036 req=0001, we0=1, addr0=18'o1000, wdata0=16'o123456, mem_ack on the 2nd XFER cycle -> mem_addr=o1000 and mem_wdata=o123456 during XFER, then ack=0001 exactly 1 cycle after mem_ack.
REQ-037 req=1111 held, zero-wait memory -> ack order 0001,0010,0100,1000,0001, spaced 3 cycles apart.
REQ-038 Read from requester 2 with mem_rdata=16'hBEEF at mem_ack -> rdata=16'hBEEF and ack=0100 in the same cycle.
REQ-039 cpu_hold=1 with req=0010 for 10 cycles -> mem_req stays 0. Release cpu_hold -> mem_req rises 1 cycle later.
REQ-040 reset_n pulsed low mid-XFER -> mem_req is 0 in the same cycle, no ack; the next grant goes to requester 0.
REQ-041 With DMA_ARB_TIMEOUT_EN defined, mem_ack never asserted -> ack and err both pulse 256 cycles after XFER entry, with rdata=0.
